// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts and an
// optional shift-add multiplier (enabled by defining SEQ_ALU_MUL_EN).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] z_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_SLL,
        K_SRL,
        K_MUL
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_step;

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    logic [WIDTH:0]   add_r;
    logic [WIDTH:0]   sub_r;
    logic [WIDTH-1:0] slt_r;
    logic [SHW-1:0]   shamt;
    logic             sgn_diff;

    assign add_r = {1'b0, a_i} + {1'b0, b_i};
    assign sub_r = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign sgn_diff = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    // Differing signs decide directly; equal signs cannot overflow.
    assign slt_r = {{(WIDTH-1){1'b0}},
                    sgn_diff ? a_i[WIDTH-1] : sub_r[WIDTH-1]};
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        z_d     = z_q;
        cout_d  = cout_q;
`ifdef SEQ_ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif

        unique case (state_q)
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                unique case (kind_q)
                    K_SLL: sh_d = {sh_q[WIDTH-2:0], 1'b0};
                    K_SRL: sh_d = {1'b0, sh_q[WIDTH-1:1]};
                    default: begin
`ifdef SEQ_ALU_MUL_EN
                        acc_d    = acc_step;
                        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
                    end
                endcase
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    z_d     = sh_d;
                    cout_d  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
                    if (kind_q == K_MUL) begin
                        z_d    = acc_step[WIDTH-1:0];
                        cout_d = |acc_step[2*WIDTH-1:WIDTH];
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_DONE;
                    cout_d  = 1'b0;
                    unique case (op_i)
                        OP_AND: z_d = a_i & b_i;
                        OP_OR:  z_d = a_i | b_i;
                        OP_ADD: begin
                            z_d    = add_r[WIDTH-1:0];
                            cout_d = add_r[WIDTH];
                        end
                        OP_SUB: begin
                            z_d    = sub_r[WIDTH-1:0];
                            cout_d = sub_r[WIDTH];
                        end
                        OP_SLT: z_d = slt_r;
                        OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a_i};
                            mplier_d = b_i;
                            cnt_d    = CW'(WIDTH);
                            kind_d   = K_MUL;
                            state_d  = S_RUN;
`else
                            z_d = '0;
`endif
                        end
                        OP_SLL, OP_SRL: begin
                            if (shamt == '0) begin
                                z_d = a_i;
                            end else begin
                                sh_d    = a_i;
                                cnt_d   = CW'(shamt);
                                kind_d  = (op_i == OP_SLL) ? K_SLL : K_SRL;
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end
        endcase

        zero_d = (z_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= K_SLL;
            cnt_q    <= '0;
            sh_q     <= '0;
            z_q      <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            z_q      <= z_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
`ifdef SEQ_ALU_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign z_o    = z_q;
    assign zero_o = zero_q;
    assign cout_o = cout_q;
    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: scoreboard of model results checked on every
// done pulse, result-hold checks between completions, latency/busy checks.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        zero;
    logic        cout;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .z_o     (z),
        .zero_o  (zero),
        .cout_o  (cout),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic        c;
        string       nm;
    } exp_t;

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lit;
    } vec_t;

    exp_t        q[$];
    logic [31:0] last_z = '0;
    logic        rst_q;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic c, output int lat);
        logic [63:0] p;
        int s;
        s   = int'(y[4:0]);
        r   = '0;
        c   = 1'b0;
        lat = 1;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin
                r = x + y;
                c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
            end
            3'b110: begin
                r = x - y;
                c = (x >= y);
            end
            3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b011: begin
`ifdef SEQ_ALU_MUL_EN
                p   = 64'(x) * 64'(y);
                r   = p[31:0];
                c   = (p >> 32) != 64'd0;
                lat = 33;
`else
                p   = '0;
                r   = p[31:0];
`endif
            end
            3'b100: begin
                r   = x << s;
                lat = (s == 0) ? 1 : s + 1;
            end
            default: begin
                r   = x >> s;
                lat = (s == 0) ? 1 : s + 1;
            end
        endcase
    endfunction

    always @(posedge clk) rst_q <= rst;

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_q === 1'b1) begin
            chk("rst_z", z, 0);
            chk("rst_zero", zero, 1);
            chk("rst_cout", cout, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            q.delete();
            last_z = '0;
        end else if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = q.pop_front();
                chk({e.nm, "_z"}, z, e.z);
                chk({e.nm, "_zero"}, zero, (e.z == 32'd0));
                chk({e.nm, "_cout"}, cout, e.c);
            end
            last_z = z;
        end else if (rst_q === 1'b0) begin
            chk("z_hold", z, last_z);
        end
    end

    task automatic push_exp(input string nm, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            output int lat);
        exp_t e;
        model(o, x, y, e.z, e.c, lat);
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic do_op(input string nm, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        int lat;
        int k;
        bit got;
        push_exp(nm, o, x, y, lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        k     = 0;
        got   = 1'b0;
        while (!got && k < 100) begin
            tick();
            k++;
            if (k == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
                op    = 3'($urandom);
            end
            if (done === 1'b1) got = 1'b1;
            else chk({nm, "_busy"}, busy, (lat > 1));
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        else chk({nm, "_latency"}, k, lat);
    endtask

    vec_t v[7];

    initial begin
        int lat;
        int k;
        bit got;

        v[0] = '{"add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000};
        v[1] = '{"sub_eq", 3'b110, 32'd5, 32'd5, 32'h0};
        v[2] = '{"slt_neg_pos", 3'b111, 32'h8000_0000, 32'h1, 32'h1};
        v[3] = '{"slt_pos_neg", 3'b111, 32'h1, 32'h8000_0000, 32'h0};
        v[4] = '{"slt_neg_neg", 3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1};
        v[5] = '{"and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        v[6] = '{"or", 3'b001, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001};

        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("after_rst_z", z, 0);
        chk("after_rst_zero", zero, 1);
        chk("after_rst_done", done, 0);
        tick();

        start = 1'b1;
        foreach (v[i]) begin
            op = v[i].op;
            a  = v[i].a;
            b  = v[i].b;
            push_exp(v[i].nm, v[i].op, v[i].a, v[i].b, lat);
            tick();
            chk({v[i].nm, "_done"}, done, 1);
            chk({v[i].nm, "_lit"}, z, v[i].lit);
        end
        start = 1'b0;
        tick();
        chk("b2b_done_drop", done, 0);

`ifdef SEQ_ALU_MUL_EN
        do_op("mul_7x6", 3'b011, 32'd7, 32'd6);
        chk("mul_7x6_lit", z, 32'd42);
        do_op("mul_ovf", 3'b011, 32'h0001_0000, 32'h0001_0000);
        chk("mul_ovf_lit", z, 32'd0);
        chk("mul_ovf_cout_lit", cout, 1);
        do_op("mul_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_max_lit", z, 32'd1);
`else
        do_op("mul_off", 3'b011, 32'd7, 32'd6);
        chk("mul_off_lit", z, 32'd0);
        chk("mul_off_zero_lit", zero, 1);
`endif

        do_op("sll_31", 3'b100, 32'h1, 32'd31);
        chk("sll_31_lit", z, 32'h8000_0000);
        do_op("srl_4", 3'b101, 32'h8000_0000, 32'd4);
        chk("srl_4_lit", z, 32'h0800_0000);
        do_op("sll_0", 3'b100, 32'h1234_ABCD, 32'd0);
        chk("sll_0_lit", z, 32'h1234_ABCD);
        do_op("srl_hib", 3'b101, 32'hF000_0000, 32'hFFFF_FFE4);
        chk("srl_hib_lit", z, 32'h0F00_0000);
        do_op("add_carry", 3'b010, 32'hFFFF_FFFF, 32'h2);
        chk("add_carry_cout_lit", cout, 1);
        tick();

        push_exp("sll_busy_start", 3'b100, 32'h1, 32'd31, lat);
        start = 1'b1;
        op    = 3'b100;
        a     = 32'h1;
        b     = 32'd31;
        k     = 0;
        got   = 1'b0;
        while (!got && k < 100) begin
            tick();
            k++;
            if (k == 1 || k == 6) start = 1'b0;
            if (k == 5) begin
                start = 1'b1;
                op    = 3'b010;
                a     = 32'd2;
                b     = 32'd3;
            end
            if (done === 1'b1) got = 1'b1;
        end
        chk("ignored_start_latency", k, lat);
        chk("ignored_start_lit", z, 32'h8000_0000);
        tick();
        chk("ignored_start_no_done", done, 0);

`ifdef SEQ_ALU_MUL_EN
        push_exp("mul_rst", 3'b011, 32'd9, 32'd9, lat);
        op = 3'b011;
`else
        push_exp("sll_rst", 3'b100, 32'h1, 32'd31, lat);
        op = 3'b100;
        b  = 32'd31;
`endif
        start = 1'b1;
        a     = 32'h1;
`ifdef SEQ_ALU_MUL_EN
        a = 32'd9;
        b = 32'd9;
`endif
        for (int i = 1; i <= 10; i++) begin
            tick();
            start = 1'b0;
            chk("pre_rst_busy", busy, 1);
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_z", z, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_done", done, 0);
        end
        do_op("add_2_3", 3'b010, 32'd2, 32'd3);
        chk("add_2_3_lit", z, 32'd5);
        tick();
        tick();

        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
